// File: rtl/flag_cond_eval_pkg.sv
// -----------------------------------------------------------------------------
// flag_pkg
//   Shared definitions for the ALU flag consumer and the branch unit:
//   condition-code encodings, the latched flag-bundle layout and the
//   holder state enum.
// -----------------------------------------------------------------------------
package flag_pkg;

  // Condition-code encodings (4-bit field).
  localparam logic [3:0] COND_EQ  = 4'd0;
  localparam logic [3:0] COND_NE  = 4'd1;
  localparam logic [3:0] COND_CS  = 4'd2;
  localparam logic [3:0] COND_CC  = 4'd3;
  localparam logic [3:0] COND_MI  = 4'd4;
  localparam logic [3:0] COND_PL  = 4'd5;
  localparam logic [3:0] COND_VS  = 4'd6;
  localparam logic [3:0] COND_VC  = 4'd7;
  localparam logic [3:0] COND_HI  = 4'd8;
  localparam logic [3:0] COND_LS  = 4'd9;
  localparam logic [3:0] COND_GE  = 4'd10;
  localparam logic [3:0] COND_LT  = 4'd11;
  localparam logic [3:0] COND_GT  = 4'd12;
  localparam logic [3:0] COND_LE  = 4'd13;
  localparam logic [3:0] COND_SLT = 4'd14;
  localparam logic [3:0] COND_AL  = 4'd15;

  // Latched flag bundle: compare bit plus the four ALU flags.
  typedef struct packed {
    logic lt;
    logic n;
    logic c;
    logic v;
    logic z;
  } flag_t;

  // Holder state: EMPTY until a bundle has been captured.
  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/flag_cond_eval_cond_decode.sv
// -----------------------------------------------------------------------------
// cond_decode
//   Purely combinational evaluation of a condition code against a flag
//   bundle. Shared with the branch unit.
//   Ports:
//     i_flags     flag bundle {lt, n, c, v, z}
//     i_cond_code condition to evaluate
//     o_taken     condition result
// -----------------------------------------------------------------------------
module cond_decode
  import flag_pkg::*;
#(
  parameter int COND_W = 4
) (
  input  flag_t             i_flags,
  input  logic [COND_W-1:0] i_cond_code,
  output logic              o_taken
);

  always_comb begin
    // NOTE: default assigned first so every path drives o_taken (no latch).
    o_taken = 1'b0;
    case (i_cond_code)
      COND_EQ:  o_taken = i_flags.z;
      COND_NE:  o_taken = !i_flags.z;
      COND_CS:  o_taken = i_flags.c;
      COND_CC:  o_taken = !i_flags.c;
      COND_MI:  o_taken = i_flags.n;
      COND_PL:  o_taken = !i_flags.n;
      COND_VS:  o_taken = i_flags.v;
      COND_VC:  o_taken = !i_flags.v;
      COND_HI:  o_taken = i_flags.c & !i_flags.z;
      COND_LS:  o_taken = !i_flags.c | i_flags.z;
      COND_GE:  o_taken = (i_flags.n == i_flags.v);
      COND_LT:  o_taken = (i_flags.n != i_flags.v);
      COND_GT:  o_taken = !i_flags.z & (i_flags.n == i_flags.v);
      COND_LE:  o_taken = i_flags.z | (i_flags.n != i_flags.v);
      COND_SLT: o_taken = i_flags.lt;
      COND_AL:  o_taken = 1'b1;
      default:  o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_cond_eval.sv
// -----------------------------------------------------------------------------
// flag_cond_eval
//   Consumer end of the ALU/compare flag interface. Latches the flag bundle,
//   answers condition-code queries with a one-cycle registered result, and
//   tracks overflow events (sticky bit + saturating counter).
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     flag_valid / flag_ready    flag bundle handshake
//     zeroFlag..negativeFlag     ALU flags; lt_bit compare result bit
//     clear                      synchronous clear of flags/sticky/counter
//     cond_valid/cond_ready      query handshake, cond_code query field
//     res_valid/res_ready        result handshake, taken result
//     sticky_ovf, ovf_count      overflow debug state
// -----------------------------------------------------------------------------
module flag_cond_eval
  import flag_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int COND_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flag_valid,
  output logic              flag_ready,
  input  logic              zeroFlag,
  input  logic              overflowFlag,
  input  logic              carryoutFlag,
  input  logic              negativeFlag,
  input  logic              lt_bit,
  input  logic              clear,
  input  logic              cond_valid,
  input  logic [COND_W-1:0] cond_code,
  output logic              cond_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              taken,
  output logic              sticky_ovf,
  output logic [CNT_W-1:0]  ovf_count
);

  state_t            r_state;
  state_t            w_state_next;
  flag_t             r_flags;
  flag_t             w_flags_in;
  logic              r_taken;
  logic              r_res_valid;
  logic              r_sticky_ovf;
  logic [CNT_W-1:0]  r_ovf_count;
  logic              w_capture;
  logic              w_accept;
  logic              w_taken_next;

  assign w_flags_in = '{lt: lt_bit, n: negativeFlag, c: carryoutFlag,
                        v: overflowFlag, z: zeroFlag};

  // clear wins over a simultaneous capture.
  assign w_capture  = flag_valid & !clear;

  // Queries need held flags and a free (or draining) result slot. Queries
  // coinciding with clear/reset are refused so they are never answered
  // against flags that are about to vanish.
  assign cond_ready = (r_state == HOLD) & (!r_res_valid | res_ready)
                      & !clear & !reset;
  assign w_accept   = cond_valid & cond_ready;

  assign flag_ready = !reset;
  assign res_valid  = r_res_valid;
  assign taken      = r_taken;
  assign sticky_ovf = r_sticky_ovf;
  assign ovf_count  = r_ovf_count;

  // Evaluated against the flags held before this edge, so a bundle captured
  // in the same cycle does not influence the query.
  cond_decode #(.COND_W(COND_W)) u_cond_decode (
    .i_flags     (r_flags),
    .i_cond_code (cond_code),
    .o_taken     (w_taken_next)
  );

  always_comb begin
    w_state_next = r_state;
    if (clear)           w_state_next = EMPTY;
    else if (flag_valid) w_state_next = HOLD;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) r_state <= EMPTY;
    else       r_state <= w_state_next;
  end

  // Latched flags and overflow tracking.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_flags      <= '0;
      r_sticky_ovf <= 1'b0;
      r_ovf_count  <= '0;
    end else if (w_capture) begin
      r_flags <= w_flags_in;
      if (overflowFlag) begin
        r_sticky_ovf <= 1'b1;
        if (r_ovf_count != {CNT_W{1'b1}})
          r_ovf_count <= r_ovf_count + CNT_W'(1);
      end
    end
  end

  // Result register; clear deliberately leaves a pending result alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_taken     <= 1'b0;
      r_res_valid <= 1'b0;
    end else if (w_accept) begin
      r_taken     <= w_taken_next;
      r_res_valid <= 1'b1;
    end else if (res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_flag_cond_eval.sv
module tb_flag_cond_eval;

  localparam int CNT_W  = 8;
  localparam int COND_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flag_valid = 1'b0;
  logic             flag_ready;
  logic             zeroFlag = 1'b0, overflowFlag = 1'b0;
  logic             carryoutFlag = 1'b0, negativeFlag = 1'b0, lt_bit = 1'b0;
  logic             clear = 1'b0;
  logic             cond_valid = 1'b0;
  logic [COND_W-1:0] cond_code = '0;
  logic             cond_ready;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic             taken;
  logic             sticky_ovf;
  logic [CNT_W-1:0] ovf_count;

  int n_pass = 0;
  int n_total = 0;

  // Scoreboard of expected taken values, one per accepted query.
  bit q_exp[$];

  // Bench-side model of the latched flags.
  bit m_z = 0, m_n = 0, m_c = 0, m_v = 0, m_l = 0;

  always #5 clk = ~clk;

  flag_cond_eval #(.CNT_W(CNT_W), .COND_W(COND_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .flag_valid   (flag_valid),
    .flag_ready   (flag_ready),
    .zeroFlag     (zeroFlag),
    .overflowFlag (overflowFlag),
    .carryoutFlag (carryoutFlag),
    .negativeFlag (negativeFlag),
    .lt_bit       (lt_bit),
    .clear        (clear),
    .cond_valid   (cond_valid),
    .cond_code    (cond_code),
    .cond_ready   (cond_ready),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .taken        (taken),
    .sticky_ovf   (sticky_ovf),
    .ovf_count    (ovf_count)
  );

  function automatic bit model_taken(input logic [3:0] code);
    bit r;
    case (code)
      4'd0:  r = m_z;
      4'd1:  r = ~m_z;
      4'd2:  r = m_c;
      4'd3:  r = ~m_c;
      4'd4:  r = m_n;
      4'd5:  r = ~m_n;
      4'd6:  r = m_v;
      4'd7:  r = ~m_v;
      4'd8:  r = m_c && !m_z;
      4'd9:  r = !(m_c && !m_z);
      4'd10: r = !(m_n ^ m_v);
      4'd11: r = m_n ^ m_v;
      4'd12: r = !m_z && !(m_n ^ m_v);
      4'd13: r = !(!m_z && !(m_n ^ m_v));
      4'd14: r = m_l;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // One clock: push expectation on acceptance, advance, update the flag
  // model, then pop and compare the produced result.
  task automatic step();
    bit acc;
    bit exp_t;
    bit cap;
    bit clr;
    bit rst;
    acc = cond_valid && cond_ready;
    if (acc) q_exp.push_back(model_taken(cond_code));
    cap = flag_valid; clr = clear; rst = reset;
    @(posedge clk);
    #1;
    if (rst || clr) begin
      m_z = 0; m_n = 0; m_c = 0; m_v = 0; m_l = 0;
    end else if (cap) begin
      m_z = zeroFlag; m_n = negativeFlag; m_c = carryoutFlag;
      m_v = overflowFlag; m_l = lt_bit;
    end
    if (acc) begin
      exp_t = q_exp.pop_front();
      n_total++;
      if (res_valid !== 1'b1 || taken !== exp_t)
        $display("FAIL sb_result res_valid=%0b taken=%0b expected res_valid=1 taken=%0b", res_valid, taken, exp_t);
      else n_pass++;
    end
  endtask

  task automatic set_flags(input bit z, input bit v, input bit c, input bit n, input bit l);
    zeroFlag = z; overflowFlag = v; carryoutFlag = c; negativeFlag = n; lt_bit = l;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    n_total++; if (flag_ready !== 1'b0) $display("FAIL reset_flag_ready got=%0b exp=0", flag_ready); else n_pass++;
    n_total++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid got=%0b exp=0", res_valid); else n_pass++;
    n_total++; if (taken !== 1'b0) $display("FAIL reset_taken got=%0b exp=0", taken); else n_pass++;
    n_total++; if (sticky_ovf !== 1'b0 || ovf_count !== '0) $display("FAIL reset_ovf sticky=%0b count=%0d exp 0/0", sticky_ovf, ovf_count); else n_pass++;
    reset = 1'b0;
    #1;
    n_total++; if (flag_ready !== 1'b1) $display("FAIL post_reset_flag_ready got=%0b exp=1", flag_ready); else n_pass++;
  endtask

  task automatic test_empty_stall();
    cond_valid = 1'b1; cond_code = 4'd15; res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_total++; if (cond_ready !== 1'b0) $display("FAIL empty_cond_ready cyc=%0d got=%0b exp=0", i, cond_ready); else n_pass++;
      step();
      n_total++; if (res_valid !== 1'b0) $display("FAIL empty_res_valid cyc=%0d got=%0b exp=0", i, res_valid); else n_pass++;
    end
    // Capture and query in the same EMPTY cycle: query must not be taken.
    flag_valid = 1'b1; set_flags(1, 0, 0, 0, 0);
    #1;
    n_total++; if (cond_ready !== 1'b0) $display("FAIL empty_capture_cond_ready got=%0b exp=0", cond_ready); else n_pass++;
    step();
    flag_valid = 1'b0;
    #1;
    n_total++; if (cond_ready !== 1'b1) $display("FAIL hold_cond_ready got=%0b exp=1", cond_ready); else n_pass++;
    step();
    n_total++; if (taken !== 1'b1) $display("FAIL first_al_taken got=%0b exp=1", taken); else n_pass++;
    cond_valid = 1'b0;
    step();
    n_total++; if (res_valid !== 1'b0) $display("FAIL drain_res_valid got=%0b exp=0", res_valid); else n_pass++;
  endtask

  task automatic test_sweep();
    bit exp_seq[14] = '{0,1,1,0,1,0,0,1,1,0,0,1,0,1};
    flag_valid = 1'b1; set_flags(0, 0, 1, 1, 0);
    step();
    flag_valid = 1'b0;
    res_ready = 1'b1; cond_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      cond_code = 4'(i);
      #1;
      n_total++; if (cond_ready !== 1'b1) $display("FAIL sweep_cond_ready code=%0d got=%0b exp=1", i, cond_ready); else n_pass++;
      step();
      n_total++; if (taken !== exp_seq[i]) $display("FAIL sweep_taken code=%0d got=%0b exp=%0b", i, taken, exp_seq[i]); else n_pass++;
    end
    cond_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    // Flags: Z=0 N=1 V=0 C=1. NE -> 1 is held, then EQ -> 0.
    res_ready = 1'b0; cond_valid = 1'b1; cond_code = 4'd1;
    step();
    cond_code = 4'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++; if (cond_ready !== 1'b0) $display("FAIL bp_cond_ready cyc=%0d got=%0b exp=0", i, cond_ready); else n_pass++;
      step();
      n_total++; if (res_valid !== 1'b1 || taken !== 1'b1) $display("FAIL bp_hold cyc=%0d res_valid=%0b taken=%0b exp 1/1", i, res_valid, taken); else n_pass++;
    end
    res_ready = 1'b1;
    #1;
    n_total++; if (cond_ready !== 1'b1) $display("FAIL bp_release_cond_ready got=%0b exp=1", cond_ready); else n_pass++;
    step();
    n_total++; if (taken !== 1'b0) $display("FAIL bp_next_taken got=%0b exp=0", taken); else n_pass++;
    cond_valid = 1'b0;
    step();
    n_total++; if (res_valid !== 1'b0) $display("FAIL bp_drain_res_valid got=%0b exp=0", res_valid); else n_pass++;
  endtask

  task automatic test_same_cycle_capture();
    // Held Z=0; capture Z=1 together with an EQ query.
    res_ready = 1'b1; cond_valid = 1'b1; cond_code = 4'd0;
    flag_valid = 1'b1; set_flags(1, 0, 0, 0, 0);
    step();
    n_total++; if (taken !== 1'b0) $display("FAIL same_cycle_taken got=%0b exp=0", taken); else n_pass++;
    flag_valid = 1'b0;
    step();
    n_total++; if (taken !== 1'b1) $display("FAIL after_capture_taken got=%0b exp=1", taken); else n_pass++;
    cond_valid = 1'b0;
    step();
  endtask

  task automatic test_overflow_clear();
    flag_valid = 1'b1; set_flags(0, 1, 0, 0, 0);
    step();
    n_total++; if (ovf_count !== 8'd1 || sticky_ovf !== 1'b1) $display("FAIL ovf_first count=%0d sticky=%0b exp 1/1", ovf_count, sticky_ovf); else n_pass++;
    for (int i = 1; i < 255; i++) step();
    n_total++; if (ovf_count !== 8'd255) $display("FAIL ovf_255 count=%0d exp=255", ovf_count); else n_pass++;
    for (int i = 255; i < 260; i++) step();
    n_total++; if (ovf_count !== 8'd255 || sticky_ovf !== 1'b1) $display("FAIL ovf_sat count=%0d sticky=%0b exp 255/1", ovf_count, sticky_ovf); else n_pass++;
    // Clear with a simultaneous capture and query: clear wins.
    clear = 1'b1; cond_valid = 1'b1; cond_code = 4'd15;
    #1;
    n_total++; if (cond_ready !== 1'b0) $display("FAIL clear_cond_ready got=%0b exp=0", cond_ready); else n_pass++;
    step();
    clear = 1'b0; flag_valid = 1'b0;
    #1;
    n_total++; if (ovf_count !== '0 || sticky_ovf !== 1'b0) $display("FAIL clear_ovf count=%0d sticky=%0b exp 0/0", ovf_count, sticky_ovf); else n_pass++;
    n_total++; if (cond_ready !== 1'b0) $display("FAIL clear_empty_cond_ready got=%0b exp=0", cond_ready); else n_pass++;
    n_total++; if (res_valid !== 1'b0) $display("FAIL clear_res_valid got=%0b exp=0", res_valid); else n_pass++;
    cond_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    flag_valid = 1'b1; set_flags(0, 1, 0, 0, 0);
    step();
    flag_valid = 1'b0;
    res_ready = 1'b0; cond_valid = 1'b1; cond_code = 4'd7;   // VC with V=1 -> 0
    step();
    cond_valid = 1'b0; cond_code = 4'd15;                    // AL -> pending taken=1
    cond_valid = 1'b1;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0; cond_valid = 1'b0;
    step();
    n_total++; if (res_valid !== 1'b1 || taken !== 1'b1) $display("FAIL pre_reset_pending res_valid=%0b taken=%0b exp 1/1", res_valid, taken); else n_pass++;
    reset = 1'b1;
    step();
    n_total++; if (res_valid !== 1'b0 || taken !== 1'b0 || ovf_count !== '0) $display("FAIL mid_reset res_valid=%0b taken=%0b count=%0d exp 0/0/0", res_valid, taken, ovf_count); else n_pass++;
    reset = 1'b0;
    flag_valid = 1'b1; set_flags(0, 0, 0, 0, 1);
    step();
    flag_valid = 1'b0;
    res_ready = 1'b1; cond_valid = 1'b1; cond_code = 4'd14;
    step();
    n_total++; if (taken !== 1'b1) $display("FAIL slt_taken got=%0b exp=1", taken); else n_pass++;
    cond_valid = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_empty_stall();
    test_sweep();
    test_backpressure();
    test_same_cycle_capture();
    test_overflow_clear();
    test_reset_mid();
    n_total++;
    if (q_exp.size() != 0) $display("FAIL scoreboard_leftover got=%0d exp=0", q_exp.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
